mem_arbiter: RTL



---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Widths, FSM state encoding and requester IDs.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RDWAIT = ST_RDWAIT,
    RESP   = ST_RESP
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner select, purely combinational.
// Ports: req[1:0] requests, last = last served ID, gnt[1:0] one-hot.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): begin
        // Contention: favour whoever was not served last.
        if (last == REQ_AUX) gnt = 2'b01;
        else                 gnt = 2'b10;
      end
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered memory port between two requesters.
// Ports: mN_* requester side, address/data_out/we/data_in memory side.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              we,
  input  logic [DATA_W-1:0] data_in
);

  state_t     state;
  state_t     state_nx;
  logic       last;
  logic       win_id;
  logic [1:0] arb_gnt;
  logic       take;
  logic       take_id;

  rr_arb2 u_arb (
    .req  ({m1_req, m0_req}),
    .last (last),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        m0_gnt = arb_gnt[REQ_CORE];
        m1_gnt = arb_gnt[REQ_AUX];
        if (arb_gnt != 2'b00) state_nx = ACCESS;
      end
      ACCESS: begin
        if (we) state_nx = IDLE;
        else    state_nx = RDWAIT;
      end
      RDWAIT:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign take    = m0_gnt | m1_gnt;
  assign take_id = m1_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      address   <= '0;
      data_out  <= '0;
      we        <= 1'b0;
      win_id    <= REQ_CORE;
      last      <= REQ_AUX;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (take) begin
        address  <= take_id ? m1_addr  : m0_addr;
        data_out <= take_id ? m1_wdata : m0_wdata;
        we       <= take_id ? m1_we    : m0_we;
        win_id   <= take_id;
        last     <= take_id;
      end
      if (state == ACCESS) we <= 1'b0;
      if (state == RDWAIT) begin
        if (win_id == REQ_AUX) begin
          m1_rdata  <= data_in;
          m1_rvalid <= 1'b1;
        end else begin
          m0_rdata  <= data_in;
          m0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
